difficulty_selector: RTL and testbench

Menu stage directly upstream of the confirmation popup. It lets the player step a cursor through difficulty levels with the up/down buttons. On select, it pulses confirm_popup to activate the popup, then waits for the popup's confirmed/canceled verdict. On confirmation it latches the chosen level and presents it to the game core as a stable, valid difficulty.

---
 rtl/difficulty_selector.sv | 154 +++++++++++++++
 tb/tb_difficulty_selector.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/difficulty_selector.sv
// Difficulty menu: cursor browsing, confirm-popup handshake and committed-level latch.
// Optional macro DIFF_TIMEOUT_EN adds an auto-cancel timeout on the popup verdict.
module difficulty_selector #(
    parameter int NUM_LEVELS      = 3,
    parameter int LVL_W           = 2,
    parameter int DEFAULT_LEVEL   = 0,
    parameter int CONFIRM_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_select,
    input  logic             confirmed,
    input  logic             canceled,
    output logic [LVL_W-1:0] cursor,
    output logic             confirm_popup,
    output logic [LVL_W-1:0] difficulty,
    output logic             difficulty_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        BROWSE       = 2'd0,
        CONFIRM_WAIT = 2'd1,
        LOCKED       = 2'd2
    } state_t;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_DEF = LVL_W'(DEFAULT_LEVEL);

    state_t           state_r, state_s;
    logic             up_prev_r, down_prev_r, sel_prev_r;
    logic             up_press_s, down_press_s, sel_press_s;
    logic [LVL_W-1:0] cursor_r, cursor_s;
    logic [LVL_W-1:0] pending_r, pending_s;
    logic [LVL_W-1:0] difficulty_r, difficulty_s;
    logic             valid_r, valid_s;
    logic             popup_r, popup_s;
    logic             busy_r;
    logic             tmo_hit_s;

`ifdef DIFF_TIMEOUT_EN
    localparam int TMO_W = (CONFIRM_TIMEOUT > 2) ? $clog2(CONFIRM_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_r;

    // Wait counter: zero outside CONFIRM_WAIT, so it is clear on every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (state_r == CONFIRM_WAIT) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= {TMO_W{1'b0}};
        end
    end

    assign tmo_hit_s = (state_r == CONFIRM_WAIT) && (tmo_r == TMO_W'(CONFIRM_TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    assign up_press_s   = btn_up     & ~up_prev_r;
    assign down_press_s = btn_down   & ~down_prev_r;
    assign sel_press_s  = btn_select & ~sel_prev_r;

    // Next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        cursor_s     = cursor_r;
        pending_s    = pending_r;
        difficulty_s = difficulty_r;
        valid_s      = valid_r;
        popup_s      = 1'b0;
        case (state_r)
            BROWSE: begin
                if (!enable) begin
                    state_s = BROWSE;
                end else if (sel_press_s) begin
                    pending_s = cursor_r;
                    popup_s   = 1'b1;
                    state_s   = CONFIRM_WAIT;
                end else if (up_press_s && !down_press_s) begin
                    cursor_s = (cursor_r == LVL_MAX) ? {LVL_W{1'b0}} : cursor_r + LVL_W'(1);
                end else if (down_press_s && !up_press_s) begin
                    cursor_s = (cursor_r == {LVL_W{1'b0}}) ? LVL_MAX : cursor_r - LVL_W'(1);
                end else begin
                    cursor_s = cursor_r;
                end
            end
            CONFIRM_WAIT: begin
                // Losing the menu aborts the request even if a verdict is arriving
                if (!enable) begin
                    state_s = BROWSE;
                end else if (confirmed) begin
                    difficulty_s = pending_r;
                    valid_s      = 1'b1;
                    state_s      = LOCKED;
                end else if (canceled || tmo_hit_s) begin
                    state_s = BROWSE;
                end else begin
                    state_s = CONFIRM_WAIT;
                end
            end
            LOCKED: begin
                if (!enable) begin
                    valid_s = 1'b0;
                    state_s = BROWSE;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = BROWSE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= BROWSE;
            up_prev_r    <= 1'b0;
            down_prev_r  <= 1'b0;
            sel_prev_r   <= 1'b0;
            cursor_r     <= LVL_DEF;
            pending_r    <= LVL_DEF;
            difficulty_r <= LVL_DEF;
            valid_r      <= 1'b0;
            popup_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            up_prev_r    <= btn_up;
            down_prev_r  <= btn_down;
            sel_prev_r   <= btn_select;
            cursor_r     <= cursor_s;
            pending_r    <= pending_s;
            difficulty_r <= difficulty_s;
            valid_r      <= valid_s;
            popup_r      <= popup_s;
            busy_r       <= (state_s == CONFIRM_WAIT);
        end
    end

    assign cursor           = cursor_r;
    assign confirm_popup    = popup_r;
    assign difficulty       = difficulty_r;
    assign difficulty_valid = valid_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_difficulty_selector.sv
// Directed self-checking bench for difficulty_selector; timeout vectors run only
// when DIFF_TIMEOUT_EN is defined.
module tb_difficulty_selector;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       btn_up, btn_down, btn_select;
    logic       confirmed, canceled;
    logic [1:0] cursor;
    logic       confirm_popup;
    logic [1:0] difficulty;
    logic       difficulty_valid;
    logic       busy;

    int checks_r = 0;
    int errors_r = 0;

    difficulty_selector #(
        .NUM_LEVELS(3), .LVL_W(2), .DEFAULT_LEVEL(0), .CONFIRM_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
        .confirmed(confirmed), .canceled(canceled),
        .cursor(cursor), .confirm_popup(confirm_popup),
        .difficulty(difficulty), .difficulty_valid(difficulty_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_up();
        btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
    endtask

    task automatic press_down();
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        confirmed = 1'b0; canceled = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_cursor", 32'(cursor), 32'd0);
        check_val("rst_diff", 32'(difficulty), 32'd0);
        check_val("rst_valid", 32'(difficulty_valid), 32'd0);
        check_val("rst_popup", 32'(confirm_popup), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        // Presses ignored while disabled
        press_up();
        check_val("dis_hold", 32'(cursor), 32'd0);

        // Browse: up 1,2, held up wraps to 0 once, down wraps to 2
        enable = 1'b1;
        btn_up = 1'b1; tick();
        check_val("up1", 32'(cursor), 32'd1);
        check_val("up1_popup", 32'(confirm_popup), 32'd0);
        btn_up = 1'b0; tick();
        press_up();
        check_val("up2", 32'(cursor), 32'd2);
        btn_up = 1'b1; tick(); tick(); tick(); btn_up = 1'b0; tick();
        check_val("up_hold_wrap", 32'(cursor), 32'd0);
        press_down();
        check_val("down_wrap", 32'(cursor), 32'd2);
        btn_up = 1'b1; btn_down = 1'b1; tick(); btn_up = 1'b0; btn_down = 1'b0; tick();
        check_val("up_down_same", 32'(cursor), 32'd2);
        press_down();
        check_val("down1", 32'(cursor), 32'd1);
        check_val("browse_popup", 32'(confirm_popup), 32'd0);

        // Select at 1, confirm later -> commit 1
        btn_select = 1'b1; tick();
        check_val("sel_popup", 32'(confirm_popup), 32'd1);
        check_val("sel_busy", 32'(busy), 32'd1);
        btn_select = 1'b0; tick();
        check_val("popup_pulse", 32'(confirm_popup), 32'd0);
        check_val("wait_busy", 32'(busy), 32'd1);
        tick(); tick();
        confirmed = 1'b1; tick(); confirmed = 1'b0;
        check_val("commit_diff", 32'(difficulty), 32'd1);
        check_val("commit_valid", 32'(difficulty_valid), 32'd1);
        check_val("commit_busy", 32'(busy), 32'd0);
        press_up();
        check_val("locked_cursor", 32'(cursor), 32'd1);
        enable = 1'b0; tick();
        check_val("unlock_valid", 32'(difficulty_valid), 32'd0);
        check_val("unlock_diff", 32'(difficulty), 32'd1);
        enable = 1'b1; tick();

        // Select at 2, ups during wait ignored, cancel
        press_up();
        check_val("to2", 32'(cursor), 32'd2);
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        press_up();
        check_val("wait_frozen", 32'(cursor), 32'd2);
        btn_up = 1'b1; canceled = 1'b1; tick(); canceled = 1'b0;
        check_val("cancel_busy", 32'(busy), 32'd0);
        check_val("cancel_valid", 32'(difficulty_valid), 32'd0);
        tick();
        check_val("held_no_press", 32'(cursor), 32'd2);
        btn_up = 1'b0; tick();
        press_up();
        check_val("after_cancel_up", 32'(cursor), 32'd0);

        // Select + up same cycle, both verdicts -> commit 0
        btn_select = 1'b1; btn_up = 1'b1; tick();
        check_val("selup_cursor", 32'(cursor), 32'd0);
        check_val("selup_popup", 32'(confirm_popup), 32'd1);
        btn_select = 1'b0; btn_up = 1'b0; tick();
        confirmed = 1'b1; canceled = 1'b1; tick(); confirmed = 1'b0; canceled = 1'b0;
        check_val("both_diff", 32'(difficulty), 32'd0);
        check_val("both_valid", 32'(difficulty_valid), 32'd1);
        canceled = 1'b1; tick(); canceled = 1'b0;
        check_val("locked_verdict", 32'(difficulty_valid), 32'd1);
        enable = 1'b0; tick(); enable = 1'b1; tick();

        // Enable drop in wait cancels
        btn_select = 1'b1; tick(); btn_select = 1'b0;
        enable = 1'b0; tick(); enable = 1'b1;
        check_val("endrop_busy", 32'(busy), 32'd0);
        check_val("endrop_valid", 32'(difficulty_valid), 32'd0);
        tick();

        // Reset during wait, with confirmed coincident -> no commit
        press_up();
        check_val("pre_rst_cursor", 32'(cursor), 32'd1);
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        rst = 1'b1; confirmed = 1'b1; tick(); rst = 1'b0;
        check_val("mid_rst_cursor", 32'(cursor), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_valid", 32'(difficulty_valid), 32'd0);
        check_val("mid_rst_diff", 32'(difficulty), 32'd0);
        tick(); confirmed = 1'b0;
        check_val("browse_verdict", 32'(difficulty_valid), 32'd0);

`ifdef DIFF_TIMEOUT_EN
        // Timeout after 8 wait cycles, then confirm on expiry cycle
        press_up(); press_up();
        btn_select = 1'b1; tick(); btn_select = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_val("tmo_busy", 32'(busy), 32'd1);
        end
        tick();
        check_val("tmo_expire", 32'(busy), 32'd0);
        check_val("tmo_valid", 32'(difficulty_valid), 32'd0);
        btn_select = 1'b1; tick(); btn_select = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        confirmed = 1'b1; tick(); confirmed = 1'b0;
        check_val("tmo_commit_valid", 32'(difficulty_valid), 32'd1);
        check_val("tmo_commit_diff", 32'(difficulty), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
